rv32m_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage.
//  Its registered result drives the M-extension data input of the 32-bit 4:1 EX/writeback

---
 rtl/rv32m_muldiv_unit_pkg.sv | 28 ++
 rtl/rv32m_muldiv_unit_if.sv | 26 ++
 rtl/rv32m_muldiv_unit_div_core.sv | 54 +++++
 rtl/rv32m_muldiv_unit.sv | 123 ++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared constants and types for the RV32M multiply/divide execute unit:
// funct3 op codes, FSM encoding and a conditional two's-complement helper.
package rv32m_muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Negate v when neg is set; also yields |v| for a signed operand.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline (master) and the M unit (slave).
// The unit answers with a registered result, a one-cycle done pulse, busy and a stall request.
interface rv32m_muldiv_unit_if;
  import rv32m_muldiv_unit_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data,
    output result, done, busy, stall
  );

endinterface

// File: rtl/rv32m_muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step, 32 steps.
// quo_o/rem_o are the values after the current step, so the final step's result is usable that cycle.
module rv32m_div_core
  import rv32m_muldiv_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q;
  logic [4:0]      cnt_q;
  logic [XLEN:0]   shifted;
  logic            fits;

  // The dividend shifts out of quo_q MSB-first while quotient bits fill in from the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    rem_d   = fits ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], fits};
  end

  assign quo_o  = quo_d;
  assign rem_o  = rem_d;
  assign last_o = (cnt_q == 5'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= 5'd31;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 5'd1;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M execute unit: MUL* done 2 cycles after accept, DIV*/REM* after 33, special cases after 1.
// Stalls the pipeline while an op is in flight; flush abandons the op without a done pulse.
module rv32m_muldiv_unit
  import rv32m_muldiv_unit_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  rv32m_muldiv_unit_if.slave mdu
);

  mdu_state_e state_q, state_d;

  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      op_q;
  logic            q_neg_q, r_neg_q;

  logic            busy, latch_en, div_load, div_step, div_last;
  logic            sgn_in, sa_in, sb_in, div_zero, div_ovf;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            a_signed, b_signed;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);

  // Operand decode for divide ops: DIV/REM are the signed ones (funct3[0] clear).
  assign sgn_in   = ~mdu.funct3[0];
  assign sa_in    = sgn_in & mdu.rs1_data[XLEN-1];
  assign sb_in    = sgn_in & mdu.rs2_data[XLEN-1];
  assign div_zero = (mdu.rs2_data == '0);
  assign div_ovf  = sgn_in && (mdu.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.rs2_data == '1);

  // 33x33 signed product, sign-extended to 64 bits; the low 64 bits are exact.
  assign a_signed = (op_q == MULH_F3) || (op_q == MULHSU_F3);
  assign b_signed = (op_q == MULH_F3);
  assign a_ext    = {{XLEN{a_signed & a_q[XLEN-1]}}, a_q};
  assign b_ext    = {{XLEN{b_signed & b_q[XLEN-1]}}, b_q};
  assign prod     = a_ext * b_ext;

  rv32m_div_core u_div_core (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (cond_neg(mdu.rs1_data, sa_in)),
    .divisor_i  (cond_neg(mdu.rs2_data, sb_in)),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    latch_en = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    if (mdu.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (mdu.start) begin
            latch_en = 1'b1;
            if (!mdu.funct3[2]) begin
              state_d = ST_MUL;
            end else if (div_zero) begin
              result_d = mdu.funct3[1] ? mdu.rs1_data : '1;
              state_d  = ST_DONE;
            end else if (div_ovf) begin
              result_d = mdu.funct3[1] ? '0 : mdu.rs1_data;
              state_d  = ST_DONE;
            end else begin
              div_load = 1'b1;
              state_d  = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_d = (op_q == MUL_F3) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (div_last) begin
            result_d = op_q[1] ? cond_neg(div_rem, r_neg_q) : cond_neg(div_quo, q_neg_q);
            state_d  = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (latch_en) begin
        op_q    <= mdu.funct3;
        a_q     <= mdu.rs1_data;
        b_q     <= mdu.rs2_data;
        q_neg_q <= sa_in ^ sb_in;
        r_neg_q <= sa_in;
      end
    end
  end

  assign mdu.result = result_q;
  assign mdu.done   = (state_q == ST_DONE);
  assign mdu.busy   = busy;
  assign mdu.stall  = (mdu.start & ~mdu.flush & ~busy) | busy;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: vector table with latency/profile checks,
// plus hand sequences for flush, async reset and back-to-back issue.
module tb_rv32m_muldiv_unit;
  import rv32m_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32m_muldiv_unit_if mdu_if ();

  rv32m_muldiv_unit dut (
    .CLK   (clk),
    .RESET (rst),
    .mdu   (mdu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op starting just after a rising edge; returns the cycle (relative to
  // the start cycle) where done was seen and the count of busy/stall profile errors.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int lat, output int done_cyc, output logic [31:0] res,
                        output int prof_err);
    done_cyc = -1;
    res      = '0;
    prof_err = 0;
    mdu_if.funct3   = f3;
    mdu_if.rs1_data = a;
    mdu_if.rs2_data = b;
    mdu_if.start    = 1'b1;
    @(negedge clk);
    if (mdu_if.stall !== 1'b1) prof_err++;
    @(posedge clk);
    #1 mdu_if.start = 1'b0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (mdu_if.busy !== (k < lat)) prof_err++;
      if (mdu_if.stall !== (k < lat)) prof_err++;
      if (mdu_if.done === 1'b1) begin
        done_cyc = k;
        res      = mdu_if.result;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          dc, perr, pulses;
    logic [31:0] res, prev;

    mdu_if.start    = 1'b0;
    mdu_if.flush    = 1'b0;
    mdu_if.funct3   = '0;
    mdu_if.rs1_data = '0;
    mdu_if.rs2_data = '0;

    tbl.push_back('{"mul_7x-3",      MUL_F3,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 2});
    tbl.push_back('{"mulh_min",      MULH_F3,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 2});
    tbl.push_back('{"mulhsu_min",    MULHSU_F3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2});
    tbl.push_back('{"mulhu_min",     MULHU_F3,  32'h80000000,   32'hFFFFFFFF, 32'h7FFFFFFF, 2});
    tbl.push_back('{"mul_ffff",      MUL_F3,    32'h0000FFFF,   32'h0000FFFF, 32'hFFFE0001, 2});
    tbl.push_back('{"mulhu_ones",    MULHU_F3,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 2});
    tbl.push_back('{"mulh_ones",     MULH_F3,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 2});
    tbl.push_back('{"div_-7/2",      DIV_F3,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33});
    tbl.push_back('{"rem_-7/2",      REM_F3,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33});
    tbl.push_back('{"divu_100/7",    DIVU_F3,   32'd100,        32'd7,        32'd14,       33});
    tbl.push_back('{"remu_100/7",    REMU_F3,   32'd100,        32'd7,        32'd2,        33});
    tbl.push_back('{"div_7/-2",      DIV_F3,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    tbl.push_back('{"rem_7/-2",      REM_F3,    32'd7,          32'hFFFFFFFE, 32'd1,        33});
    tbl.push_back('{"divu_big/-1",   DIVU_F3,   32'h80000000,   32'hFFFFFFFF, 32'd0,        33});
    tbl.push_back('{"remu_big/-1",   REMU_F3,   32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33});
    tbl.push_back('{"remu_ones/16",  REMU_F3,   32'hFFFFFFFF,   32'd16,       32'h0000000F, 33});
    tbl.push_back('{"divu_5/0",      DIVU_F3,   32'd5,          32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{"rem_5/0",       REM_F3,    32'd5,          32'd0,        32'd5,        1});
    tbl.push_back('{"remu_9/0",      REMU_F3,   32'd9,          32'd0,        32'd9,        1});
    tbl.push_back('{"div_0/0",       DIV_F3,    32'd0,          32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{"div_ovf",       DIV_F3,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
    tbl.push_back('{"rem_ovf",       REM_F3,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1});
    tbl.push_back('{"div_min/2",     DIV_F3,    32'h80000000,   32'd2,        32'hC0000000, 33});

    // Reset state, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", mdu_if.result, 32'd0);
    check("rst_done",   {31'd0, mdu_if.done}, 32'd0);
    check("rst_busy",   {31'd0, mdu_if.busy}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_result", mdu_if.result, 32'd0);
    check("idle_done",   {31'd0, mdu_if.done}, 32'd0);
    check("idle_stall",  {31'd0, mdu_if.stall}, 32'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].lat, dc, res, perr);
      check({tbl[i].name, "_latency"}, dc, tbl[i].lat);
      check({tbl[i].name, "_result"},  res, tbl[i].exp);
      check({tbl[i].name, "_profile_errs"}, perr, 32'd0);
      @(negedge clk);
      check({tbl[i].name, "_hold_done"},   {31'd0, mdu_if.done}, 32'd0);
      check({tbl[i].name, "_hold_result"}, mdu_if.result, tbl[i].exp);
      @(posedge clk);
      #1;
    end
    prev = tbl[tbl.size()-1].exp;

    // Flush in cycle T+10 of a DIV
    mdu_if.funct3   = DIVU_F3;
    mdu_if.rs1_data = 32'd100;
    mdu_if.rs2_data = 32'd7;
    mdu_if.start    = 1'b1;
    @(posedge clk);
    #1 mdu_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 mdu_if.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {31'd0, mdu_if.busy}, 32'd1);
    @(posedge clk);
    #1 mdu_if.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after",  {31'd0, mdu_if.busy}, 32'd0);
    check("flush_stall_after", {31'd0, mdu_if.stall}, 32'd0);
    check("flush_result_kept", mdu_if.result, prev);
    pulses = (mdu_if.done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdu_if.done === 1'b1) pulses++;
    end
    check("flush_no_done", pulses, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-DIV
    mdu_if.funct3   = DIV_F3;
    mdu_if.rs1_data = 32'hFFFFFFF9;
    mdu_if.rs2_data = 32'd2;
    mdu_if.start    = 1'b1;
    @(posedge clk);
    #1 mdu_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_result", mdu_if.result, 32'd0);
    check("arst_busy",   {31'd0, mdu_if.busy}, 32'd0);
    check("arst_done",   {31'd0, mdu_if.done}, 32'd0);
    check("arst_stall",  {31'd0, mdu_if.stall}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdu_if.done === 1'b1 || mdu_if.busy === 1'b1) pulses++;
    end
    check("arst_no_done", pulses, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: start held through a MUL's DONE cycle
    mdu_if.funct3   = MUL_F3;
    mdu_if.rs1_data = 32'd7;
    mdu_if.rs2_data = 32'hFFFFFFFD;
    mdu_if.start    = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.rs1_data = 32'h0000FFFF;
    mdu_if.rs2_data = 32'h0000FFFF;
    @(negedge clk);
    check("b2b_t1_busy", {31'd0, mdu_if.busy}, 32'd1);
    check("b2b_t1_done", {31'd0, mdu_if.done}, 32'd0);
    @(negedge clk);
    check("b2b_t2_done",   {31'd0, mdu_if.done}, 32'd1);
    check("b2b_t2_result", mdu_if.result, 32'hFFFFFFEB);
    @(posedge clk);
    #1 mdu_if.start = 1'b0;
    @(negedge clk);
    check("b2b_t3_busy", {31'd0, mdu_if.busy}, 32'd1);
    check("b2b_t3_done", {31'd0, mdu_if.done}, 32'd0);
    @(negedge clk);
    check("b2b_t4_done",   {31'd0, mdu_if.done}, 32'd1);
    check("b2b_t4_result", mdu_if.result, 32'hFFFE0001);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mdu_if.done === 1'b1 || mdu_if.busy === 1'b1) pulses++;
    end
    check("b2b_no_extra_op", pulses, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
